pc_fetch_unit: RTL

//  Instruction-fetch stage that consumes the branch unit's redirect (PcSel, BrPC).

---
 rtl/pc_fetch_unit_pkg.sv | 25 ++
 rtl/pc_fetch_unit_if.sv | 28 ++
 rtl/pc_fetch_unit_ifid_reg.sv | 23 ++
 rtl/pc_fetch_unit.sv | 100 ++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage types: FSM state encoding, IF/ID payload and the bubble word.
// The decode stage imports this package as well.
package pc_fetch_unit_pkg;

  localparam int          PC_W      = 9;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } ifid_t;

  // A redirect target is bad if it is not word aligned or does not fit in PC_W bits.
  function automatic logic bad_target(input logic [31:0] target);
    return (target[1:0] != 2'b00) || (|target[31:PC_W]);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: branch redirect, hazard/halt controls, instruction ROM and IF/ID outputs.
// The fetch unit is the slave; the surrounding core (or a bench) is the master.
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;

  logic            stall;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            halt_req;
  logic [PC_W-1:0] inst_addr;
  logic [31:0]     inst_data;
  logic [PC_W-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  logic            ifid_valid;
  logic            halted;
  logic            addr_err;

  modport master (
    output stall, PcSel, BrPC, halt_req, inst_data,
    input  inst_addr, ifid_pc, ifid_instr, ifid_valid, halted, addr_err
  );

  modport slave (
    input  stall, PcSel, BrPC, halt_req, inst_data,
    output inst_addr, ifid_pc, ifid_instr, ifid_valid, halted, addr_err
  );

endinterface

// File: rtl/pc_fetch_unit_ifid_reg.sv
// IF/ID pipeline register: flush (or reset) writes a bubble, load captures the fetched
// word, otherwise the contents hold.
module pc_fetch_unit_ifid_reg
  import pc_fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [PC_W-1:0] pc_d,
  input  logic [31:0]     instr_d,
  output ifid_t           q
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
    end else if (load) begin
      q <= '{pc: pc_d, instr: instr_d, valid: 1'b1};
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: PC register, next-PC selection, halt-drain FSM and sticky
// redirect-address error; the fetched word is registered into IF/ID.
//
//   state  | meaning
//   RUN    | fetching; redirect > stall > halt > sequential advance
//   DRAIN  | PC frozen, bubbles issued while older instructions retire
//   HALTED | core stopped until reset
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              DRAIN_CYC = 3
) (
  input  logic            clk,
  input  logic            reset,
  pc_fetch_unit_if.slave  bus
);

  localparam int              CNT_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYC - 1);

  fetch_state_t     state;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] drain_cnt;
  logic             halted_q;
  logic             addr_err_q;
  logic             ifid_load;
  logic             ifid_flush;
  ifid_t            ifid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      pc         <= RESET_PC;
      drain_cnt  <= '0;
      halted_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.PcSel) begin
            // A pending halt here sits on the wrong path and is dropped.
            pc <= {bus.BrPC[PC_W-1:2], 2'b00};
            if (bad_target(bus.BrPC)) addr_err_q <= 1'b1;
          end else if (!bus.stall) begin
            if (bus.halt_req) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end else begin
              pc <= pc + PC_W'(4);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == CNT_LAST) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
        HALTED: halted_q <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (state == RUN) begin
      if (bus.PcSel) begin
        ifid_flush = 1'b1;
      end else if (!bus.stall) begin
        ifid_flush = bus.halt_req;
        ifid_load  = !bus.halt_req;
      end
    end else begin
      ifid_flush = 1'b1;
    end
  end

  pc_fetch_unit_ifid_reg u_ifid (
    .clk     (clk),
    .reset   (reset),
    .load    (ifid_load),
    .flush   (ifid_flush),
    .pc_d    (pc),
    .instr_d (bus.inst_data),
    .q       (ifid_q)
  );

  assign bus.inst_addr  = pc;
  assign bus.ifid_pc    = ifid_q.pc;
  assign bus.ifid_instr = ifid_q.instr;
  assign bus.ifid_valid = ifid_q.valid;
  assign bus.halted     = halted_q;
  assign bus.addr_err   = addr_err_q;

endmodule
